// File: rtl/instr_fetch_queue_pkg.sv
// ---------------------------------------------------------------------------
// instr_fetch_queue_pkg
//   Shared constants and types for the instruction fetch queue:
//     IFQ_NOP       - instruction word presented downstream when the queue is empty
//     IFQ_RESET_PC  - default first fetch address after reset
//     ifq_state_e   - fetch FSM encoding (IFQ_FETCH / IFQ_DRAIN)
//     ifq_entry_t   - one queue entry {instr, pc}
//     ifq_next_pc() - sequential PC step (wraps mod 2^32)
// ---------------------------------------------------------------------------
package instr_fetch_queue_pkg;

    localparam logic [31:0] IFQ_NOP      = 32'h0000_0000;
    localparam logic [31:0] IFQ_RESET_PC = 32'hBFC0_0000;

    typedef enum logic {
        IFQ_FETCH = 1'b0,
        IFQ_DRAIN = 1'b1
    } ifq_state_e;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } ifq_entry_t;

    function automatic logic [31:0] ifq_next_pc(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/instr_fetch_queue_fifo.sv
// ---------------------------------------------------------------------------
// ifq_fifo
//   In-order DEPTH x {instr, pc} queue. Push and pop may happen in the same
//   cycle at any occupancy, including full. clear empties the queue and has
//   priority over push/pop.
//   Ports:
//     clk, reset                 - clock, synchronous active-high reset
//     clear                      - drop all entries this cycle
//     push, push_instr, push_pc  - enqueue one entry
//     pop                        - dequeue the head (ignored when empty)
//     head_instr, head_pc        - current head entry (undefined when empty)
//     count, empty, full         - occupancy
// ---------------------------------------------------------------------------
module ifq_fifo
    import instr_fetch_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             push,
    input  logic [31:0]      push_instr,
    input  logic [31:0]      push_pc,
    input  logic             pop,
    output logic [31:0]      head_instr,
    output logic [31:0]      head_pc,
    output logic [CNT_W-1:0] count,
    output logic             empty,
    output logic             full
);

    ifq_entry_t       mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign do_pop  = pop && !empty;
    // A pop frees the slot at the same edge, so a push into a full queue is
    // legal when it is paired with a pop.
    assign do_push = push && (!full || do_pop);

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !clear && !reset) begin
            mem[wr_ptr] <= '{instr: push_instr, pc: push_pc};
        end
    end

    assign head_instr = mem[rd_ptr].instr;
    assign head_pc    = mem[rd_ptr].pc;

endmodule

// File: rtl/instr_fetch_queue.sv
// ---------------------------------------------------------------------------
// instr_fetch_queue
//   IF stage producer: issues instruction-memory fetches, buffers returned
//   words in order and presents the head to the IF/ID register. An empty
//   queue presents a NOP bubble (instr IFQ_NOP, pc 0, pc+4 0).
//
//   Optional feature macro: IFQ_PERF_EN builds a saturating bubble counter on
//   PERF_BUBBLES; without it PERF_BUBBLES is tied to 0.
//
//   Ports:
//     CLK, RESET            - clock, synchronous active-high reset
//     STALL                 - IF/ID frozen, hold the head
//     REDIRECT, REDIRECT_PC - flush queue and in-flight fetches, restart at PC
//     IMEM_REQ, IMEM_ADDR   - fetch request (issue when IMEM_ACK also high)
//     IMEM_ACK              - memory accepts the request this cycle
//     IMEM_RVALID/RDATA     - in-order fetch responses
//     Instr1_IF             - head instruction
//     Instr_PC_IF           - head PC
//     Instr_PC_Plus4_IF     - head PC + 4
//     PERF_BUBBLES          - count of NOP bubbles handed downstream
// ---------------------------------------------------------------------------
module instr_fetch_queue
    import instr_fetch_queue_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter int          MAX_OUT  = 2,
    parameter logic [31:0] RESET_PC = IFQ_RESET_PC
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        STALL,
    input  logic        REDIRECT,
    input  logic [31:0] REDIRECT_PC,
    output logic        IMEM_REQ,
    output logic [31:0] IMEM_ADDR,
    input  logic        IMEM_ACK,
    input  logic        IMEM_RVALID,
    input  logic [31:0] IMEM_RDATA,
    output logic [31:0] Instr1_IF,
    output logic [31:0] Instr_PC_IF,
    output logic [31:0] Instr_PC_Plus4_IF,
    output logic [31:0] PERF_BUBBLES
);

    localparam int               CNT_W     = $clog2(DEPTH) + 1;
    localparam logic [CNT_W:0]   DEPTH_LIM = (CNT_W + 1)'(DEPTH);
    localparam logic [CNT_W-1:0] OUT_LIM   = CNT_W'(MAX_OUT);

    ifq_state_e       state;
    logic [31:0]      fetch_pc;
    logic [31:0]      resp_pc;
    logic [CNT_W-1:0] outstanding;
    logic [CNT_W-1:0] drop_cnt;
    logic [CNT_W-1:0] drop_next;
    logic [CNT_W:0]   credit_sum;

    logic             rsp;
    logic             issue;
    logic             push;
    logic             pop;
    logic [31:0]      head_instr;
    logic [31:0]      head_pc;
    logic [CNT_W-1:0] count;
    logic             empty;
    logic             full;

    // Responses with nothing in flight are stray (memory's fault); ignoring
    // them keeps the counters from wrapping.
    assign rsp = IMEM_RVALID && (outstanding != '0);

    // Credit rule: every outstanding fetch already owns a queue slot, so a
    // response can always be pushed without checking for space.
    assign credit_sum = {1'b0, count} + {1'b0, outstanding};

    assign IMEM_REQ  = !RESET && !REDIRECT && (state == IFQ_FETCH) &&
                       (outstanding < OUT_LIM) && !full &&
                       (credit_sum < DEPTH_LIM);
    assign IMEM_ADDR = fetch_pc;
    assign issue     = IMEM_REQ && IMEM_ACK;

    assign push = (state == IFQ_FETCH) && rsp && !REDIRECT;
    assign pop  = !STALL && !empty && !REDIRECT;

    // In-flight fetches left over after a redirect; a response arriving in
    // the redirect cycle itself is discarded immediately, and no new issue
    // can happen that cycle because IMEM_REQ is forced low.
    assign drop_next = outstanding - CNT_W'(rsp);

    // Fetch FSM, PC trackers, in-flight and drop counters.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state       <= IFQ_FETCH;
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else if (REDIRECT) begin
            fetch_pc    <= REDIRECT_PC;
            resp_pc     <= REDIRECT_PC;
            outstanding <= drop_next;
            drop_cnt    <= drop_next;
            state       <= (drop_next != '0) ? IFQ_DRAIN : IFQ_FETCH;
        end else begin
            case (state)
                IFQ_FETCH: begin
                    if (issue) fetch_pc <= ifq_next_pc(fetch_pc);
                    if (rsp)   resp_pc  <= ifq_next_pc(resp_pc);
                    outstanding <= outstanding + CNT_W'(issue) - CNT_W'(rsp);
                end
                IFQ_DRAIN: begin
                    if (rsp) begin
                        outstanding <= outstanding - 1'b1;
                        drop_cnt    <= drop_cnt - 1'b1;
                        if (drop_cnt == CNT_W'(1)) state <= IFQ_FETCH;
                    end else if (drop_cnt == '0) begin
                        state <= IFQ_FETCH;
                    end
                end
                default: state <= IFQ_FETCH;
            endcase
        end
    end

    ifq_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk        (CLK),
        .reset      (RESET),
        .clear      (REDIRECT),
        .push       (push),
        .push_instr (IMEM_RDATA),
        .push_pc    (resp_pc),
        .pop        (pop),
        .head_instr (head_instr),
        .head_pc    (head_pc),
        .count      (count),
        .empty      (empty),
        .full       (full)
    );

    assign Instr1_IF         = empty ? IFQ_NOP : head_instr;
    assign Instr_PC_IF       = empty ? 32'h0   : head_pc;
    assign Instr_PC_Plus4_IF = empty ? 32'h0   : ifq_next_pc(head_pc);

`ifdef IFQ_PERF_EN
    // A bubble is handed downstream whenever IF/ID loads while we are empty.
    logic [31:0] bubble_cnt;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            bubble_cnt <= '0;
        end else if (!STALL && empty && (bubble_cnt != 32'hFFFF_FFFF)) begin
            bubble_cnt <= bubble_cnt + 32'd1;
        end
    end

    assign PERF_BUBBLES = bubble_cnt;
`else
    assign PERF_BUBBLES = 32'h0;
`endif

endmodule
